ddr3_bank_cont: RTL and testbench

DDR3_BANK_CONT -- requirements
Module: ddr3_bank_cont

---
 rtl/ddr3_mem_pkg.sv | 26 ++
 rtl/ddr3_bank_cont_if.sv | 27 ++
 rtl/ddr3_bank_tracker.sv | 41 ++++
 rtl/ddr3_bank_cont.sv | 243 ++++++++++++++++++++++++
 tb/tb_ddr3_bank_cont.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_mem_pkg.sv
// Shared types for the DDR3 single-bank-at-a-time controller.
//   cmd_e : {cs_n,ras_n,cas_n,we_n} command encodings driven on the DRAM pins
//   st_e  : controller FSM states
//   max2  : helper used to size the shared wait counter
package ddr3_mem_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'b0111,
      CMD_ACT = 4'b0011,
      CMD_RD  = 4'b0101,
      CMD_WR  = 4'b0100,
      CMD_PRE = 4'b0010,
      CMD_REF = 4'b0001,
      CMD_ZQC = 4'b0110
   } cmd_e;

   typedef enum logic [3:0] {
      ST_INIT, ST_ZQ, ST_IDLE, ST_PRE, ST_ACT,
      ST_WR_BURST, ST_RD_WAIT, ST_RD_BURST, ST_REF_PRE, ST_REF
   } st_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ddr3_bank_cont_if.sv
// CPU-side request/response bus of ddr3_bank_cont.
//   req_valid/req_ready : request handshake (accept = valid && ready)
//   req_wr, req_ba, req_row, req_col, wr_data : request fields, latched at accept
//   rd_data/rd_valid    : assembled read burst and its one-cycle qualifier
// Modports: master = CPU side, slave = controller side.
interface ddr3_bank_cont_if #(
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 4,
   parameter int BA_W      = 3,
   parameter int ROW_W     = 15,
   parameter int COL_W     = 10
);
   logic                          req_valid;
   logic                          req_ready;
   logic                          req_wr;
   logic [BA_W-1:0]               req_ba;
   logic [ROW_W-1:0]              req_row;
   logic [COL_W-1:0]              req_col;
   logic [DATA_W*BURST_LEN-1:0]   wr_data;
   logic [DATA_W*BURST_LEN-1:0]   rd_data;
   logic                          rd_valid;

   modport master (output req_valid, req_wr, req_ba, req_row, req_col, wr_data,
                   input  req_ready, rd_data, rd_valid);
   modport slave  (input  req_valid, req_wr, req_ba, req_row, req_col, wr_data,
                   output req_ready, rd_data, rd_valid);
endinterface

// File: rtl/ddr3_bank_tracker.sv
// Open-row table: one valid bit and one row address per bank.
//   clk_i, rst_i (sync, active high)
//   lk_ba_i/lk_row_i -> open_o (bank has an open row), hit_o (open on lk_row_i)
//   set_i  : mark upd_ba_i open on set_row_i (ACT)
//   clr_i  : mark upd_ba_i closed (PRE)
//   clr_all_i : close every bank (after refresh)
module ddr3_bank_tracker #(
   parameter int NUM_BANKS = 8,
   parameter int ROW_W     = 15,
   localparam int BA_W     = $clog2(NUM_BANKS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [BA_W-1:0]  lk_ba_i,
   input  logic [ROW_W-1:0] lk_row_i,
   output logic             open_o,
   output logic             hit_o,
   input  logic             set_i,
   input  logic             clr_i,
   input  logic             clr_all_i,
   input  logic [BA_W-1:0]  upd_ba_i,
   input  logic [ROW_W-1:0] set_row_i
);
   logic [NUM_BANKS-1:0]            vld_q;
   logic [NUM_BANKS-1:0][ROW_W-1:0] row_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_all_i) begin
         vld_q <= '0;
         row_q <= '0;
      end else if (set_i) begin
         vld_q[upd_ba_i] <= 1'b1;
         row_q[upd_ba_i] <= set_row_i;
      end else if (clr_i) begin
         vld_q[upd_ba_i] <= 1'b0;
      end
   end

   assign open_o = vld_q[lk_ba_i];
   assign hit_o  = open_o && (row_q[lk_ba_i] == lk_row_i);
endmodule

// File: rtl/ddr3_bank_cont.sv
// DDR3 controller: one request at a time, open-page policy per bank.
//   cpu_clk, reset (sync, active high), en (leave INIT)
//   cpu  : ddr3_bank_cont_if.slave request/response bus
//   mem_cke, mem_cs_n/ras_n/cas_n/we_n, mem_ba, mem_addr : DRAM command pins
//   mem_wr_data/mem_wr_en : write beat and drive enable; mem_rd_data : read beat
// Optional: define DDR3_REFRESH_EN to add periodic PRE-all + REF every TREFI cycles.
// Every timed state issues its command on its first cycle (counter at its load
// value) and exits when the shared down-counter reaches zero.
module ddr3_bank_cont
   import ddr3_mem_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 4,
   parameter int NUM_BANKS = 8,
   parameter int ROW_W     = 15,
   parameter int COL_W     = 10,
   parameter int TRP       = 3,
   parameter int TRCD      = 3,
   parameter int TCL       = 5,
   parameter int TRFC      = 20,
   parameter int TREFI     = 1560,
   localparam int BA_W     = $clog2(NUM_BANKS)
) (
   input  logic              cpu_clk,
   input  logic              reset,
   input  logic              en,
   ddr3_bank_cont_if.slave   cpu,
   output logic              mem_cke,
   output logic              mem_cs_n,
   output logic              mem_ras_n,
   output logic              mem_cas_n,
   output logic              mem_we_n,
   output logic [BA_W-1:0]   mem_ba,
   output logic [ROW_W-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_rd_data
);
   localparam int CNT_MAX = max2(max2(TRP, TRCD), max2(max2(TCL, TRFC), BURST_LEN));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BI_W    = $clog2(BURST_LEN);
   localparam logic [ROW_W-1:0] A10 = ROW_W'(1) << 10;

   st_e                              st_q, st_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [BI_W-1:0]                  beat;
   logic                             wr_q;
   logic [BA_W-1:0]                  ba_q;
   logic [ROW_W-1:0]                 row_q;
   logic [COL_W-1:0]                 col_q;
   logic [BURST_LEN-1:0][DATA_W-1:0] wdata_q;
   logic [BURST_LEN-1:0][DATA_W-1:0] rbuf_q, rbuf_d;
   logic [BURST_LEN-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
   logic                             rd_valid_q, rd_valid_d;
   logic                             accept, pend;
   logic                             trk_open, trk_hit, trk_set, trk_clr, trk_clr_all;
   cmd_e                             cmd;

   assign cpu.req_ready = (st_q == ST_IDLE) && !pend;
   assign accept        = cpu.req_valid && cpu.req_ready;
   assign cpu.rd_data   = rd_data_q;
   assign cpu.rd_valid  = rd_valid_q;
   assign mem_cke       = (st_q != ST_INIT);
   assign {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} = cmd;
   // burst states count down from BURST_LEN-1, so beat index is the complement
   assign beat = BI_W'(CNT_W'(BURST_LEN - 1) - cnt_q);

   ddr3_bank_tracker #(.NUM_BANKS(NUM_BANKS), .ROW_W(ROW_W)) u_trk (
      .clk_i(cpu_clk), .rst_i(reset),
      .lk_ba_i(cpu.req_ba), .lk_row_i(cpu.req_row),
      .open_o(trk_open), .hit_o(trk_hit),
      .set_i(trk_set), .clr_i(trk_clr), .clr_all_i(trk_clr_all),
      .upd_ba_i(ba_q), .set_row_i(row_q)
   );

`ifdef DDR3_REFRESH_EN
   localparam int RC_W = $clog2(TREFI + 1);
   logic [RC_W-1:0] ref_cnt_q;
   logic            pend_q, ref_done, ref_tick;

   assign ref_tick = (st_q != ST_INIT) && (st_q != ST_ZQ) && (ref_cnt_q == RC_W'(TREFI - 1));
   assign pend     = pend_q;

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         ref_cnt_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (st_q != ST_INIT && st_q != ST_ZQ)
            ref_cnt_q <= ref_tick ? '0 : ref_cnt_q + RC_W'(1);
         pend_q <= (pend_q && !ref_done) || ref_tick;
      end
   end
`else
   assign pend = 1'b0;
`endif

   always_comb begin
      st_d        = st_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      cmd         = CMD_NOP;
      mem_ba      = '0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      trk_set     = 1'b0;
      trk_clr     = 1'b0;
      trk_clr_all = 1'b0;
      rbuf_d      = rbuf_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
`ifdef DDR3_REFRESH_EN
      ref_done    = 1'b0;
`endif
      case (st_q)
         ST_INIT: if (en) st_d = ST_ZQ;
         ST_ZQ: begin
            cmd  = CMD_ZQC;
            st_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (pend) begin
               st_d  = ST_REF_PRE;
               cnt_d = CNT_W'(TRP);
            end else if (accept) begin
               if (trk_hit) begin
                  st_d  = cpu.req_wr ? ST_WR_BURST : ST_RD_WAIT;
                  cnt_d = cpu.req_wr ? CNT_W'(BURST_LEN) : CNT_W'(TCL - 1);
               end else if (trk_open) begin
                  st_d  = ST_PRE;
                  cnt_d = CNT_W'(TRP);
               end else begin
                  st_d  = ST_ACT;
                  cnt_d = CNT_W'(TRCD);
               end
            end
         end
         ST_PRE: begin
            if (cnt_q == CNT_W'(TRP)) begin
               cmd     = CMD_PRE;
               mem_ba  = ba_q;
               trk_clr = 1'b1;
            end
            if (cnt_q == '0) begin
               st_d  = ST_ACT;
               cnt_d = CNT_W'(TRCD);
            end
         end
         ST_ACT: begin
            if (cnt_q == CNT_W'(TRCD)) begin
               cmd      = CMD_ACT;
               mem_ba   = ba_q;
               mem_addr = row_q;
               trk_set  = 1'b1;
            end
            if (cnt_q == '0) begin
               st_d  = wr_q ? ST_WR_BURST : ST_RD_WAIT;
               cnt_d = wr_q ? CNT_W'(BURST_LEN) : CNT_W'(TCL - 1);
            end
         end
         ST_WR_BURST: begin
            if (cnt_q == CNT_W'(BURST_LEN)) begin
               cmd      = CMD_WR;
               mem_ba   = ba_q;
               mem_addr = ROW_W'(col_q);
            end else begin
               mem_wr_en   = 1'b1;
               mem_wr_data = wdata_q[beat];
            end
            if (cnt_q == '0) st_d = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (cnt_q == CNT_W'(TCL - 1)) begin
               cmd      = CMD_RD;
               mem_ba   = ba_q;
               mem_addr = ROW_W'(col_q);
            end
            if (cnt_q == '0) begin
               st_d  = ST_RD_BURST;
               cnt_d = CNT_W'(BURST_LEN - 1);
            end
         end
         ST_RD_BURST: begin
            rbuf_d[beat] = mem_rd_data;
            // publish the whole burst at once so rd_data holds between reads
            if (cnt_q == '0) begin
               st_d       = ST_IDLE;
               rd_data_d  = rbuf_d;
               rd_valid_d = 1'b1;
            end
         end
`ifdef DDR3_REFRESH_EN
         ST_REF_PRE: begin
            if (cnt_q == CNT_W'(TRP)) begin
               cmd      = CMD_PRE;
               mem_addr = A10;
            end
            if (cnt_q == '0) begin
               st_d  = ST_REF;
               cnt_d = CNT_W'(TRFC);
            end
         end
         ST_REF: begin
            if (cnt_q == CNT_W'(TRFC)) cmd = CMD_REF;
            if (cnt_q == '0) begin
               st_d        = ST_IDLE;
               trk_clr_all = 1'b1;
               ref_done    = 1'b1;
            end
         end
`endif
         default: st_d = ST_INIT;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         st_q       <= ST_INIT;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         ba_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         wdata_q    <= '0;
         rbuf_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         rbuf_q     <= rbuf_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         if (accept) begin
            wr_q    <= cpu.req_wr;
            ba_q    <= cpu.req_ba;
            row_q   <= cpu.req_row;
            col_q   <= cpu.req_col;
            wdata_q <= cpu.wr_data;
         end
      end
   end
endmodule

// File: tb/tb_ddr3_bank_cont.sv
// Directed bench for ddr3_bank_cont: reset/ZQ bring-up, closed-bank write,
// row-hit read, row-miss read, reset during RD_WAIT, and (with
// DDR3_REFRESH_EN) the PRE-all / REF sequence with TREFI=50.
module tb_ddr3_bank_cont;
   import ddr3_mem_pkg::*;

   localparam int DATA_W = 16;
   localparam int BL     = 4;
   localparam int BA_W   = 3;
   localparam int ROW_W  = 15;
   localparam int COL_W  = 10;

   logic              cpu_clk = 1'b0;
   logic              reset   = 1'b1;
   logic              en      = 1'b0;
   logic              mem_cke, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n, mem_wr_en;
   logic [BA_W-1:0]   mem_ba;
   logic [ROW_W-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data = '0;
   int                n_chk = 0;
   int                n_err = 0;

   ddr3_bank_cont_if #(.DATA_W(DATA_W), .BURST_LEN(BL), .BA_W(BA_W),
                       .ROW_W(ROW_W), .COL_W(COL_W)) cpu ();

   ddr3_bank_cont #(.DATA_W(DATA_W), .BURST_LEN(BL), .TREFI(50)) dut (
      .cpu_clk(cpu_clk), .reset(reset), .en(en), .cpu(cpu),
      .mem_cke(mem_cke), .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n),
      .mem_cas_n(mem_cas_n), .mem_we_n(mem_we_n), .mem_ba(mem_ba),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
      .mem_rd_data(mem_rd_data)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] cmd_now();
      return {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n};
   endfunction

   // present a request, wait for acceptance; returns in the cycle after accept
   task automatic issue(input logic wr, input logic [BA_W-1:0] ba, input logic [ROW_W-1:0] row,
                        input logic [COL_W-1:0] col, input logic [63:0] d);
      int w;
      w = 0;
      cpu.req_wr = wr; cpu.req_ba = ba; cpu.req_row = row; cpu.req_col = col;
      cpu.wr_data = d; cpu.req_valid = 1'b1;
      while (!cpu.req_ready && w < 100) begin tick(); w++; end
      if (w >= 100) chk("ready_timeout", 64'd0, 64'd1);
      tick();
      cpu.req_valid = 1'b0;
   endtask

   // called in the RD cycle: plays beats at RD+5..RD+8, expects rd_valid at RD+9
   task automatic rd_return(input string tag, input logic [63:0] beats, input logic [63:0] old);
      for (int j = 1; j <= 9; j++) begin
         tick();
         if (j >= 5 && j <= 8) mem_rd_data = beats[(j-5)*DATA_W +: DATA_W];
         if (j == 8) begin
            chk({tag, "_vld_early"}, 64'(cpu.rd_valid), 64'd0);
            chk({tag, "_data_hold"}, cpu.rd_data, old);
         end
      end
      chk({tag, "_vld"}, 64'(cpu.rd_valid), 64'd1);
      chk({tag, "_data"}, cpu.rd_data, beats);
      tick();
      chk({tag, "_vld_pulse"}, 64'(cpu.rd_valid), 64'd0);
   endtask

   task automatic nops(input string tag, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (cmd_now() != CMD_NOP) bad++;
      end
      chk(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      int bad;
      logic [63:0] wd;
      cpu.req_valid = 1'b0; cpu.req_wr = 1'b0; cpu.req_ba = '0;
      cpu.req_row = '0; cpu.req_col = '0; cpu.wr_data = '0;
      wd = 64'h4444_3333_2222_1111;

      // reset values
      tick(); tick();
      chk("rst_cke", 64'(mem_cke), 64'd0);
      chk("rst_cmd", 64'(cmd_now()), 64'(CMD_NOP));
      chk("rst_ready", 64'(cpu.req_ready), 64'd0);
      chk("rst_rdvld", 64'(cpu.rd_valid), 64'd0);
      chk("rst_rddata", cpu.rd_data, 64'd0);
      chk("rst_ba_addr", 64'({mem_ba, mem_addr}), 64'd0);
      reset = 1'b0;
      tick(); tick();
      chk("init_cke", 64'(mem_cke), 64'd0);
      chk("init_ready", 64'(cpu.req_ready), 64'd0);

      // bring-up: ZQC one cycle after en, then idle
      en = 1'b1;
      tick();
      chk("zq_cmd", 64'(cmd_now()), 64'(CMD_ZQC));
      chk("zq_cke", 64'(mem_cke), 64'd1);
      tick();
      chk("idle_ready", 64'(cpu.req_ready), 64'd1);

      // write to closed bank: ACT, 3 NOP, WR, 4 beats
      issue(1'b1, 3'd2, 15'h10, 10'h8, wd);
      chk("wr_act", 64'(cmd_now()), 64'(CMD_ACT));
      chk("wr_act_addr", 64'({mem_ba, mem_addr}), 64'({3'd2, 15'h10}));
      nops("wr_trcd", 3);
      tick();
      chk("wr_cmd", 64'(cmd_now()), 64'(CMD_WR));
      chk("wr_col", 64'({mem_ba, mem_addr}), 64'({3'd2, 15'h8}));
      chk("wr_en_cmd", 64'(mem_wr_en), 64'd0);
      for (int k = 0; k < BL; k++) begin
         tick();
         chk("wr_beat_en", 64'(mem_wr_en), 64'd1);
         chk("wr_beat", 64'(mem_wr_data), 64'(wd[k*DATA_W +: DATA_W]));
      end
      tick();
      chk("wr_done_en", 64'(mem_wr_en), 64'd0);
`ifndef DDR3_REFRESH_EN
      chk("wr_done_ready", 64'(cpu.req_ready), 64'd1);

      // read hit: RD next cycle
      issue(1'b0, 3'd2, 15'h10, 10'h8, 64'd0);
      chk("hit_rd", 64'(cmd_now()), 64'(CMD_RD));
      chk("hit_rd_col", 64'(mem_addr), 64'h8);
      rd_return("hit", wd, 64'd0);

      // read miss: PRE, 3 NOP, ACT, 3 NOP, RD
      issue(1'b0, 3'd2, 15'h11, 10'h4, 64'd0);
      chk("miss_pre", 64'(cmd_now()), 64'(CMD_PRE));
      chk("miss_pre_ba", 64'(mem_ba), 64'd2);
      chk("miss_pre_a10", 64'(mem_addr[10]), 64'd0);
      nops("miss_trp", 3);
      tick();
      chk("miss_act", 64'(cmd_now()), 64'(CMD_ACT));
      chk("miss_act_row", 64'(mem_addr), 64'h11);
      nops("miss_trcd", 3);
      tick();
      chk("miss_rd", 64'(cmd_now()), 64'(CMD_RD));
      chk("miss_rd_col", 64'(mem_addr), 64'h4);
      rd_return("miss", 64'hDEAD_BEEF_CAFE_0123, wd);

      // reset while in RD_WAIT: burst aborted
      issue(1'b0, 3'd2, 15'h11, 10'h0, 64'd0);
      chk("abort_rd", 64'(cmd_now()), 64'(CMD_RD));
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("abort_cke", 64'(mem_cke), 64'd0);
      chk("abort_cmd", 64'(cmd_now()), 64'(CMD_NOP));
      chk("abort_ready", 64'(cpu.req_ready), 64'd0);
      chk("abort_rddata", cpu.rd_data, 64'd0);
      chk("abort_addr", 64'({mem_ba, mem_addr, mem_wr_en}), 64'd0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu.rd_valid) bad++;
      end
      chk("abort_no_rdvld", 64'(bad), 64'd0);
      // table cleared by reset: same row now needs ACT
      issue(1'b0, 3'd2, 15'h11, 10'h0, 64'd0);
      chk("abort_reopen_act", 64'(cmd_now()), 64'(CMD_ACT));
`else
      // refresh: PRE-all, 3 NOP, REF, 20 NOP, ready low throughout
      bad = 0;
      for (int i = 0; i < 100 && bad == 0; i++) begin
         tick();
         if (cmd_now() == CMD_PRE && mem_addr[10]) bad = 1;
      end
      chk("ref_pre_all", 64'(bad), 64'd1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cpu.req_ready || cmd_now() != CMD_NOP) bad++;
      end
      tick();
      chk("ref_cmd", 64'(cmd_now()), 64'(CMD_REF));
      for (int i = 0; i < 20; i++) begin
         if (cpu.req_ready) bad++;
         tick();
         if (cmd_now() != CMD_NOP) bad++;
      end
      chk("ref_wait_quiet", 64'(bad), 64'd0);
      tick();
      chk("ref_ready_back", 64'(cpu.req_ready), 64'd1);
      issue(1'b0, 3'd2, 15'h10, 10'h8, 64'd0);
      chk("ref_reopen_act", 64'(cmd_now()), 64'(CMD_ACT));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
